reg_scoreboard: RTL

- Producer-side companion to the EX-stage forwarding unit. It tracks which architectural registers have outstanding long-latency writes (loads and other multi-cycle results) that cannot yet be forwarded.
- It raises a decode-stage stall when a consumer in ID reads such a register.
- It sits between ID (issue/query) and WB (retire/clear), with a kill port from the flush logic.

---
 rtl/reg_scoreboard_if.sv | 48 ++++
 rtl/reg_scoreboard.sv | 111 +++++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue / query / retire / kill bundle between ID, WB, flush logic and the register scoreboard.
interface reg_scoreboard_if #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
);
    localparam int unsigned IDX_W = $clog2(NREG);
    // Wide enough to hold every non-zero register saturated at the same time.
    localparam int unsigned SUM_W = $clog2((NREG - 1) * ((1 << CNT_W) - 1) + 1);

    // ID -> EX issue of a (possibly long-latency) producer
    logic             iss_fire;
    logic [IDX_W-1:0] iss_rd;
    logic             iss_long;

    // ID-stage operand / destination query
    logic             q_rs1_en;
    logic [IDX_W-1:0] q_rs1;
    logic             q_rs2_en;
    logic [IDX_W-1:0] q_rs2;
    logic [IDX_W-1:0] q_rd;
    logic             q_rd_long;

    // WB retire and EX squash of long-latency producers
    logic             wb_valid;
    logic [IDX_W-1:0] wb_rd;
    logic             kill_valid;
    logic [IDX_W-1:0] kill_rd;

    // Scoreboard responses
    logic             stall;
    logic [NREG-1:0]  busy_vec;
    logic [SUM_W-1:0] outstanding;
    logic             err_underflow;

    modport master (
        output iss_fire, iss_rd, iss_long,
               q_rs1_en, q_rs1, q_rs2_en, q_rs2, q_rd, q_rd_long,
               wb_valid, wb_rd, kill_valid, kill_rd,
        input  stall, busy_vec, outstanding, err_underflow
    );

    modport slave (
        input  iss_fire, iss_rd, iss_long,
               q_rs1_en, q_rs1, q_rs2_en, q_rs2, q_rd, q_rd_long,
               wb_valid, wb_rd, kill_valid, kill_rd,
        output stall, busy_vec, outstanding, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register outstanding long-latency write counters with an ID-stage RAW/WAW stall.
module reg_scoreboard #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_scoreboard_if.slave bus
);
    localparam int unsigned SUM_W = $clog2((NREG - 1) * ((1 << CNT_W) - 1) + 1);
    // Two guard bits: one for the sign, one for a single-step overshoot above max.
    localparam int unsigned ACC_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [ACC_W-1:0] acc   [NREG];

    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_wb_v;
    logic [NREG-1:0]  dec_k_v;
    logic [NREG-1:0]  busy_d;
    logic [SUM_W-1:0] sum_d;
    logic             uf_d;

    logic             bypass1;
    logic             bypass2;
    logic             raw1;
    logic             raw2;
    logic             waw_full;

    // Decode issue / retire / kill into one-hot per-register events; x0 never takes events.
    always_comb begin
        inc_v    = '0;
        dec_wb_v = '0;
        dec_k_v  = '0;
        if (bus.iss_fire && bus.iss_long) begin
            inc_v[bus.iss_rd] = 1'b1;
        end
        if (bus.wb_valid) begin
            dec_wb_v[bus.wb_rd] = 1'b1;
        end
        if (bus.kill_valid) begin
            dec_k_v[bus.kill_rd] = 1'b1;
        end
        inc_v[0]    = 1'b0;
        dec_wb_v[0] = 1'b0;
        dec_k_v[0]  = 1'b0;
    end

    // Next counter values: arithmetic composition of all events, clamped to [0, max].
    always_comb begin
        uf_d = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            acc[i] = ACC_W'(cnt_q[i]) + ACC_W'(inc_v[i])
                   - ACC_W'(dec_wb_v[i]) - ACC_W'(dec_k_v[i]);
            if (acc[i][ACC_W-1]) begin
                cnt_d[i] = '0;
                uf_d     = 1'b1;
            end else if (acc[i][ACC_W-2:CNT_W] != '0) begin
                cnt_d[i] = CNT_MAX;
            end else begin
                cnt_d[i] = acc[i][CNT_W-1:0];
            end
        end
        cnt_d[0] = '0;
    end

    // Busy bits and total outstanding writes, both taken from the next-state counters.
    always_comb begin
        sum_d  = '0;
        busy_d = '0;
        for (int i = 0; i < NREG; i++) begin
            sum_d     = sum_d + SUM_W'(cnt_d[i]);
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    // ID stall: RAW on a pending write unless the last one retires now with no kill on it; WAW when full.
    always_comb begin
        bypass1  = (cnt_q[bus.q_rs1] == CNT_ONE) && bus.wb_valid && (bus.wb_rd == bus.q_rs1)
                 && !(bus.kill_valid && (bus.kill_rd == bus.q_rs1));
        bypass2  = (cnt_q[bus.q_rs2] == CNT_ONE) && bus.wb_valid && (bus.wb_rd == bus.q_rs2)
                 && !(bus.kill_valid && (bus.kill_rd == bus.q_rs2));
        raw1     = bus.q_rs1_en && (bus.q_rs1 != '0) && (cnt_q[bus.q_rs1] != '0) && !bypass1;
        raw2     = bus.q_rs2_en && (bus.q_rs2 != '0) && (cnt_q[bus.q_rs2] != '0) && !bypass2;
        waw_full = bus.q_rd_long && (bus.q_rd != '0) && (cnt_q[bus.q_rd] == CNT_MAX);
    end

    assign bus.stall = raw1 || raw2 || waw_full;

    // Counter state and registered status outputs; underflow flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            bus.busy_vec      <= '0;
            bus.outstanding   <= '0;
            bus.err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            bus.busy_vec      <= busy_d;
            bus.outstanding   <= sum_d;
            bus.err_underflow <= bus.err_underflow | uf_d;
        end
    end
endmodule
